// File: rtl/mem_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_writeback_stage
// Brief   : Memory-access and writeback stage with a 2^ADDR_WIDTH x DATA_WIDTH
//           data memory, a sequential clear engine and an optional debug view
//           port (enable with `define MEM_VIEW_PORT_EN).
// Revision: 1.0 - initial release
// ============================================================================
module mem_writeback_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_overflow,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic                      reg_write,
  input  logic                      reset_memory,
  output logic                      wb_valid,
  output logic                      wb_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      wb_overflow,
  output logic                      wb_addr_error,
  input  logic                      view,
  input  logic [ADDR_WIDTH-1:0]     view_address,
  output logic [DATA_WIDTH-1:0]     data_contents,
  output logic                      clearing
);

  localparam int                    c_depth     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clr_ptr;
  logic [DATA_WIDTH-1:0]   r_mem [0:c_depth-1];

  logic                      r_m_valid;
  logic [DATA_WIDTH-1:0]     r_m_result;
  logic                      r_m_ovf;
  logic [DATA_WIDTH-1:0]     r_m_store;
  logic [REG_ADDR_WIDTH-1:0] r_m_dest;
  logic                      r_m_rd;
  logic                      r_m_wr;
  logic                      r_m_rw;

  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_m_addr;
  logic                    w_hi_nonzero;
  logic                    w_addr_err;
  logic                    w_store;
  logic [DATA_WIDTH-1:0]   w_wb_data;

  assign in_ready = (r_state == S_RUN) && !reset_memory;
  assign clearing = (r_state == S_CLEAR);
  assign w_accept = in_valid && in_ready;

  // Clear engine: a clear request while already clearing restarts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (reset_memory) begin
            r_clr_ptr <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
            if (r_clr_ptr == c_last_addr) r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (reset_memory) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_ptr <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_valid  <= 1'b0;
      r_m_result <= '0;
      r_m_ovf    <= 1'b0;
      r_m_store  <= '0;
      r_m_dest   <= '0;
      r_m_rd     <= 1'b0;
      r_m_wr     <= 1'b0;
      r_m_rw     <= 1'b0;
    end else begin
      r_m_valid <= w_accept;
      if (w_accept) begin
        r_m_result <= alu_result;
        r_m_ovf    <= alu_overflow;
        r_m_store  <= store_data;
        r_m_dest   <= dest_reg;
        r_m_rd     <= mem_read;
        r_m_wr     <= mem_write;
        r_m_rw     <= reg_write;
      end
    end
  end

  assign w_m_addr = r_m_result[ADDR_WIDTH-1:0];

  generate
    if (DATA_WIDTH > ADDR_WIDTH) begin : g_addr_hi
      assign w_hi_nonzero = |r_m_result[DATA_WIDTH-1:ADDR_WIDTH];
    end else begin : g_no_addr_hi
      assign w_hi_nonzero = 1'b0;
    end
  endgenerate

  assign w_addr_err = w_hi_nonzero && (r_m_rd || r_m_wr);
  assign w_store    = r_m_valid && r_m_wr && !w_addr_err;

  // Single write port; a store draining from M never coincides with a clear
  // write because input is blocked for the whole clear.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[w_m_addr] <= r_m_store;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end
  end

  always_comb begin
    w_wb_data = r_m_result;
    if (r_m_rd && !r_m_wr) begin
      w_wb_data = w_addr_err ? '0 : r_mem[w_m_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_reg        <= '0;
      wb_data       <= '0;
      wb_overflow   <= 1'b0;
      wb_addr_error <= 1'b0;
    end else begin
      wb_valid <= r_m_valid;
      if (r_m_valid) begin
        wb_reg_write  <= r_m_rw && !r_m_ovf && !(r_m_rd && w_addr_err);
        wb_reg        <= r_m_dest;
        wb_data       <= w_wb_data;
        wb_overflow   <= r_m_ovf;
        wb_addr_error <= w_addr_err;
      end else begin
        wb_reg_write  <= 1'b0;
        wb_reg        <= '0;
        wb_data       <= '0;
        wb_overflow   <= 1'b0;
        wb_addr_error <= 1'b0;
      end
    end
  end

`ifdef MEM_VIEW_PORT_EN
  logic [DATA_WIDTH-1:0] r_view_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_view_data <= '0;
    end else begin
      r_view_data <= (view && (r_state == S_RUN)) ? r_mem[view_address] : '0;
    end
  end

  assign data_contents = r_view_data;
`else
  logic w_view_unused;

  assign w_view_unused = ^{view, view_address};
  assign data_contents = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_writeback_stage
// Brief   : Scoreboard bench for mem_writeback_stage with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_writeback_stage;

`ifdef MEM_VIEW_PORT_EN
  localparam bit c_view_en = 1'b1;
`else
  localparam bit c_view_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic        alu_overflow = 1'b0;
  logic [31:0] store_data = '0;
  logic [4:0]  dest_reg = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        reg_write = 1'b0;
  logic        reset_memory = 1'b0;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_overflow;
  logic        wb_addr_error;
  logic        view = 1'b0;
  logic [7:0]  view_address = '0;
  logic [31:0] data_contents;
  logic        clearing;

  mem_writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .store_data(store_data),
    .dest_reg(dest_reg), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reset_memory(reset_memory), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_overflow(wb_overflow), .wb_addr_error(wb_addr_error), .view(view),
    .view_address(view_address), .data_contents(data_contents), .clearing(clearing)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rg;
    logic [31:0] data;
    logic        ovf;
    logic        aerr;
    logic [31:0] cyc;
  } wb_t;

  wb_t         sb_q[$];
  int          nchecks = 0;
  int          nerrors = 0;
  logic [31:0] cyc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every writeback pulse must match the oldest pending op, including its cycle.
  always @(negedge clk) begin
    wb_t act;
    wb_t exp;
    if (wb_valid) begin
      if (sb_q.size() == 0) begin
        nchecks++;
        nerrors++;
        $display("FAIL wb_unexpected: got wb_valid=1 data=%h, required no pending writeback", wb_data);
      end else begin
        exp = sb_q.pop_front();
        act = '{rw: wb_reg_write, rg: wb_reg, data: wb_data, ovf: wb_overflow,
                aerr: wb_addr_error, cyc: cyc};
        chk("wb", act, exp);
      end
    end
  end

  // Called one time unit after a rising edge; returns at the same phase one cycle later.
  task automatic issue(input logic [31:0] res, input logic ovf, input logic [31:0] sd,
                       input logic [4:0] dr, input logic rd, input logic wr, input logic rw,
                       input logic [31:0] e_data, input logic e_rw, input logic e_aerr);
    in_valid     = 1'b1;
    alu_result   = res;
    alu_overflow = ovf;
    store_data   = sd;
    dest_reg     = dr;
    mem_read     = rd;
    mem_write    = wr;
    reg_write    = rw;
    chk("issue_ready", in_ready, 1);
    sb_q.push_back('{rw: e_rw, rg: dr, data: e_data, ovf: ovf, aerr: e_aerr, cyc: cyc + 2});
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic count_clear(output int n, output int not_ready);
    n = 0;
    not_ready = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!clearing) break;
      n++;
      if (in_ready) not_ready++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clearing", clearing, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_view", data_contents, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    count_clear(n, nr);
    chk("clear_len", n, 256);
    chk("clear_ready_low", nr, 0);
    chk("ready_after_clear", in_ready, 1);
    @(posedge clk);
    #1;

    view = 1'b1;
    view_address = 8'h3F;
    @(posedge clk);
    #1;
    chk("view_3f", data_contents, 0);
    view = 1'b0;

    // res, ovf, store, dest, rd, wr, rw, expected data, expected rw, expected aerr
    issue(32'h10,       0, 32'hDEADBEEF, 5'd0, 0, 1, 0, 32'h10,       0, 0);
    issue(32'h10,       0, 32'h0,        5'd7, 1, 0, 1, 32'hDEADBEEF, 1, 0);
    issue(32'h7FFFFFFF, 1, 32'h0,        5'd3, 0, 0, 1, 32'h7FFFFFFF, 0, 0);
    issue(32'h12345678, 0, 32'h0,        5'd9, 0, 0, 1, 32'h12345678, 1, 0);
    issue(32'h100,      0, 32'h0,        5'd4, 1, 0, 1, 32'h0,        0, 1);
    issue(32'h1FF,      0, 32'hCAFEF00D, 5'd0, 0, 1, 0, 32'h1FF,      0, 1);
    issue(32'hFF,       0, 32'h0,        5'd5, 1, 0, 1, 32'h0,        1, 0);
    issue(32'h30,       0, 32'h11112222, 5'd6, 1, 1, 1, 32'h30,       1, 0);
    issue(32'h30,       0, 32'h0,        5'd8, 1, 0, 1, 32'h11112222, 1, 0);
    drain();

    view = 1'b1;
    view_address = 8'h10;
    @(posedge clk);
    #1;
    chk("view_10", data_contents, c_view_en ? 32'hDEADBEEF : 32'h0);
    view = 1'b0;
    @(posedge clk);
    #1;
    chk("view_off", data_contents, 0);

    // Store followed immediately by a clear request.
    issue(32'h20, 0, 32'h55, 5'd0, 0, 1, 0, 32'h20, 0, 0);
    reset_memory = 1'b1;
    #1;
    chk("rm_ready_low", in_ready, 0);
    @(posedge clk);
    #1 reset_memory = 1'b0;
    count_clear(n, nr);
    chk("rm_clear_len", n, 256);
    chk("rm_clear_ready_low", nr, 0);
    @(posedge clk);
    #1;
    issue(32'h20, 0, 32'h0, 5'd10, 1, 0, 1, 32'h0, 1, 0);
    issue(32'h10, 0, 32'h0, 5'd11, 1, 0, 1, 32'h0, 1, 0);
    drain();

    // Reset pulse with one op in W and another in M.
    issue(32'h40, 0, 32'h9999, 5'd0, 0, 1, 0, 32'h40, 0, 0);
    in_valid   = 1'b1;
    alu_result = 32'h50;
    store_data = 32'h7777;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_clearing", clearing, 1);
    chk("mid_rst_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    count_clear(n, nr);
    chk("mid_rst_clear_len", n, 256);
    @(posedge clk);
    #1;
    issue(32'h40, 0, 32'h0, 5'd12, 1, 0, 1, 32'h0, 1, 0);
    issue(32'h50, 0, 32'h0, 5'd13, 1, 0, 1, 32'h0, 1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_writeback_stage.md
# mem_writeback_stage

Downstream of the ALU: accepts one executed operation per cycle (ALU result, overflow, store data, control bits), performs the data-memory access, and presents a registered writeback to the register file. Owns the 256×32 data memory, its sequential clear engine (driven by the datapath controller's memory-reset request) and the debug view port (`view`/`view_address` → `data_contents`).

## Interface
- `DATA_WIDTH`, 32, data and ALU result width
- `ADDR_WIDTH`, 8, data-memory word-address width; depth = 2^ADDR_WIDTH
- `REG_ADDR_WIDTH`, 5, register-file destination index width
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high
- `in_valid` in 1: operation presented
- `in_ready` out 1: stage accepts; transfer when `in_valid && in_ready`
- `alu_result` in DATA_WIDTH: ALU result; low ADDR_WIDTH bits are the memory address for loads and stores
- `alu_overflow` in 1: ALU overflow for this operation
- `store_data` in DATA_WIDTH: operand B value to store
- `dest_reg` in REG_ADDR_WIDTH: writeback register
- `mem_read`, `mem_write`, `reg_write` in 1 each: operation controls
- `reset_memory` in 1: request to clear the data memory
- `wb_valid` out 1: writeback slot valid this cycle
- `wb_reg_write` out 1: register file write enable
- `wb_reg` out REG_ADDR_WIDTH; `wb_data` out DATA_WIDTH
- `wb_overflow` out 1; `wb_addr_error` out 1
- `view` in 1; `view_address` in ADDR_WIDTH; `data_contents` out DATA_WIDTH
- `clearing` out 1: clear engine active

## Operation
- Two registers: M (accepted operation) and W (writeback outputs). FSM states CLEAR, RUN.
- `reset` asserted: state=CLEAR, clear pointer=0, M and W invalid, all outputs 0 except `clearing`=1. Memory array itself has no reset.
- CLEAR: writes 0 to mem[pointer] each cycle, pointer+1; after writing address 2^ADDR_WIDTH−1 → RUN. Takes exactly 2^ADDR_WIDTH cycles.
- RUN: `in_ready` = !`reset_memory`. `reset_memory` high in RUN → CLEAR, pointer=0 at that edge; in CLEAR it restarts pointer at 0.
- M→W at next edge:
  - Address error: `alu_result` bits above ADDR_WIDTH nonzero with `mem_read` or `mem_write` → store suppressed, load data 0, `wb_addr_error`=1.
  - `mem_write` (wins if `mem_read` also set): mem[addr]←`store_data`; `wb_data`=`alu_result`.
  - `mem_read` only: `wb_data`=mem[addr] (array value before this edge).
  - Neither: `wb_data`=`alu_result`.
  - `wb_reg_write` = `reg_write && !alu_overflow && !(mem_read && addr_error)`; `wb_overflow`=`alu_overflow`.
- Operation in M when clearing begins completes normally (store lands, then clear overwrites).
- View: `data_contents` registered; = mem[`view_address`] when `view` and RUN, else 0.

## Timing
- Accept at edge k → M valid cycle k..k+1 → W (`wb_*`) valid for the cycle after edge k+1 (latency 2). Throughput 1/cycle in RUN.
- Store at edge k+1 visible to a load accepted at edge k+1 (read at edge k+2); no hazard.
- `in_ready` low throughout CLEAR and in any cycle `reset_memory` is high.
- `wb_valid` is a one-cycle pulse per operation; no backpressure from the register file.
- `data_contents`: one-cycle latency from `view`/`view_address`.

## Configuration
- `MEM_VIEW_PORT_EN` defined: view port as above.
- Undefined: `data_contents` tied 0, `view`/`view_address` ignored, no view read mux or register.

## Test plan
- Reset released → `clearing`=1 for 256 cycles, `in_ready`=0; then `in_ready`=1, view of address 0x3F returns 0.
- Store `store_data`=0xDEADBEEF at `alu_result`=0x10, then load 0x10 with `dest_reg`=7 back-to-back → load wb cycle: `wb_data`=0xDEADBEEF, `wb_reg`=7, `wb_reg_write`=1.
- ALU op `alu_result`=0x7FFFFFFF, `alu_overflow`=1, `reg_write`=1 → `wb_overflow`=1, `wb_reg_write`=0, `wb_valid`=1.
- Load `alu_result`=0x100 → `wb_data`=0, `wb_addr_error`=1, `wb_reg_write`=0; store 0x1FF writes nothing (mem[0xFF] unchanged).
- Store 0x55 at 0x20 with `reset_memory` asserted the next cycle → `in_ready` drops, 256-cycle clear, mem[0x20] reads 0 afterward.
- `reset` pulsed mid-stream with ops in M and W → `wb_valid` 0 immediately, no store lands, CLEAR restarts at 0.
